// File: rtl/phv_deparser_pkg.sv
// Shared types, tuser field offsets and keep-mask helper for phv_deparser.
package phv_deparser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } state_t;

    localparam int LEN_LSB    = 0;
    localparam int LEN_W      = 16;
    localparam int DPORT_LSB  = 24;
    localparam int DPORT_W    = 8;
    localparam int MAX_KEEP_W = 128;

    // Low r bytes valid; r == bus width gives all ones.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int r);
        logic [MAX_KEEP_W-1:0] m;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            m[i] = (i < r);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream output stage.
module axis_out_reg #(
    parameter int DW = 256,
    parameter int TU = 128
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    input  logic [DW/8-1:0] in_keep,
    input  logic [TU-1:0]   in_user,
    input  logic            in_last,
    output logic            out_ready,
    output logic [DW-1:0]   m_axis_tdata,
    output logic [DW/8-1:0] m_axis_tkeep,
    output logic [TU-1:0]   m_axis_tuser,
    output logic            m_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready
);

    assign out_ready = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else if (out_ready) begin
            m_axis_tvalid <= in_valid;
            if (in_valid) begin
                m_axis_tdata <= in_data;
                m_axis_tkeep <= in_keep;
                m_axis_tuser <= in_user;
                m_axis_tlast <= in_last;
            end
        end
    end

endmodule

// File: rtl/phv_deparser.sv
// PHV deparser: overlays PHV header segments onto the leading packet beats.
// Define PHV_DEPARSER_PAYLOAD_FWD_EN to forward payload instead of truncating.
module phv_deparser
    import phv_deparser_pkg::*;
#(
    parameter int         C_S_AXIS_DATA_WIDTH  = 256,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter int         HDR_BEATS            = 4,
    parameter int         LEN_WIDTH            = 16,
    parameter logic [7:0] DST_PORT             = 8'h04,
    parameter int         PHV_WIDTH            =
        HDR_BEATS * C_S_AXIS_DATA_WIDTH + LEN_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tlast,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [PHV_WIDTH-1:0]                 phv_data,
    input  logic                                 phv_valid,
    output logic                                 phv_ready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [31:0]                          pkt_cnt,
    output logic [31:0]                          short_cnt
);

    localparam int DW   = C_S_AXIS_DATA_WIDTH;
    localparam int TU   = C_S_AXIS_TUSER_WIDTH;
    localparam int B    = DW / 8;
    localparam int MAXL = HDR_BEATS * B;
    localparam int IW   = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam int NSEG = 2 ** IW;

    state_t          state;
    state_t          nstate;
    logic [IW-1:0]   k;
    logic [IW-1:0]   nk;
    logic [IW-1:0]   kk;
    logic            bypass;
    logic            nbypass;
    logic            active;
    logic            out_ready;
    logic            fire;
    logic            hdr_beat;
    logic            idle_pass;
    logic            is_last;
    logic            ld;
    logic            phv_take;
    logic            short_inc;
    logic [DW-1:0]   o_data;
    logic [B-1:0]    o_keep;
    logic [TU-1:0]   o_user;
    logic            o_last;
    logic [B-1:0]    last_keep;
    logic [LEN_WIDTH-1:0] len_raw;
    int              len_i;
    int              h_i;
    int              r_i;
    logic [DW-1:0]   segs [NSEG];

    for (genvar j = 0; j < NSEG; j++) begin : g_seg
        if (j < HDR_BEATS) begin : g_on
            assign segs[j] = phv_data[j*DW +: DW];
        end else begin : g_off
            assign segs[j] = '0;
        end
    end

    assign len_raw = phv_data[HDR_BEATS*DW +: LEN_WIDTH];

    always_comb begin
        len_i = int'(len_raw);
        if (len_i > MAXL) begin
            len_i = MAXL;
        end
        h_i       = (len_i + B - 1) / B;
        r_i       = len_i - (h_i - 1) * B;
        last_keep = B'(keep_mask(r_i));
    end

    // A new packet may start only when its PHV is present.
    always_comb begin
        s_axis_tready = active && ((state == DROP) ||
                        (out_ready && (state != IDLE || phv_valid)));
    end

    assign fire      = s_axis_tvalid && s_axis_tready;
    assign kk        = (state == HDR) ? k : '0;
    assign is_last   = (int'(kk) == h_i - 1);
    assign hdr_beat  = (state == IDLE && h_i != 0) ||
                       (state == HDR && !bypass);
    assign idle_pass = (state == IDLE) && (h_i == 0);
    assign phv_ready = phv_take;

    always_comb begin
        ld        = 1'b0;
        phv_take  = 1'b0;
        short_inc = 1'b0;
        o_data    = s_axis_tdata;
        o_keep    = s_axis_tkeep;
        o_user    = s_axis_tuser;
        o_last    = s_axis_tlast;
        nstate    = state;
        nk        = k;
        nbypass   = bypass;
        if (fire) begin
            unique case (1'b1)
                (state == DROP): begin
                    if (s_axis_tlast) nstate = IDLE;
                end
                hdr_beat: begin
                    ld     = 1'b1;
                    o_data = segs[kk];
                    o_keep = '1;
                    if (state == IDLE) begin
                        o_user[DPORT_LSB +: DPORT_W] = DST_PORT;
`ifndef PHV_DEPARSER_PAYLOAD_FWD_EN
                        o_user[LEN_LSB +: LEN_W] = LEN_W'(len_i);
`endif
                    end
                    if (is_last) begin
                        phv_take = 1'b1;
                        nk       = '0;
`ifdef PHV_DEPARSER_PAYLOAD_FWD_EN
                        o_keep = s_axis_tkeep;
                        o_last = s_axis_tlast;
                        nstate = s_axis_tlast ? IDLE : PAYLOAD;
`else
                        o_keep = last_keep;
                        o_last = 1'b1;
                        nstate = s_axis_tlast ? IDLE : DROP;
`endif
                    end else if (s_axis_tlast) begin
                        phv_take  = 1'b1;
                        short_inc = 1'b1;
                        o_keep    = s_axis_tkeep;
                        o_last    = 1'b1;
                        nstate    = IDLE;
                        nk        = '0;
                    end else begin
                        o_last = 1'b0;
                        nstate = HDR;
                        nk     = kk + 1'b1;
                    end
                end
                idle_pass: begin
                    ld       = 1'b1;
                    phv_take = 1'b1;
`ifdef PHV_DEPARSER_PAYLOAD_FWD_EN
                    nstate = s_axis_tlast ? IDLE : PAYLOAD;
`else
                    // Zero-length PHV: stream the body through HDR unmodified.
                    nstate  = s_axis_tlast ? IDLE : HDR;
                    nbypass = !s_axis_tlast;
`endif
                end
                default: begin
                    ld = 1'b1;
                    if (s_axis_tlast) begin
                        nstate  = IDLE;
                        nbypass = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            k         <= '0;
            bypass    <= 1'b0;
            active    <= 1'b0;
            pkt_cnt   <= '0;
            short_cnt <= '0;
        end else begin
            active <= 1'b1;
            state  <= nstate;
            k      <= nk;
            bypass <= nbypass;
            if (ld && o_last) pkt_cnt <= pkt_cnt + 32'd1;
            if (short_inc) short_cnt <= short_cnt + 32'd1;
        end
    end

    axis_out_reg #(
        .DW(DW),
        .TU(TU)
    ) u_out (
        .clk          (clk),
        .aresetn      (aresetn),
        .in_valid     (ld),
        .in_data      (o_data),
        .in_keep      (o_keep),
        .in_user      (o_user),
        .in_last      (o_last),
        .out_ready    (out_ready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

endmodule

// File: tb/tb_phv_deparser.sv
// Directed self-checking bench for phv_deparser (DW=256, HDR_BEATS=4).
module tb_phv_deparser;

    localparam int DW = 256;
    localparam int TU = 128;
    localparam int HB = 4;
    localparam int LW = 16;
    localparam int KW = DW / 8;
    localparam int PW = HB * DW + LW;
    localparam int OW = DW + KW + TU + 1;
`ifdef PHV_DEPARSER_PAYLOAD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [TU-1:0] s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [PW-1:0] phv_data;
    logic          phv_valid;
    logic          phv_ready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [TU-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   pkt_cnt;
    logic [31:0]   short_cnt;

    int checks = 0;
    int failures = 0;
    int phv_pulses = 0;
    int stall_err = 0;
    int first_in = -1;
    int last_in = -1;

    logic [DW-1:0] iq_data [$];
    logic [KW-1:0] iq_keep [$];
    logic [TU-1:0] iq_user [$];
    logic          iq_last [$];
    logic [PW-1:0] pq [$];
    logic [OW-1:0] oq [$];
    logic [OW-1:0] exq [$];

    phv_deparser #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(TU),
        .HDR_BEATS           (HB),
        .LEN_WIDTH           (LW),
        .DST_PORT            (8'h04),
        .PHV_WIDTH           (PW)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .phv_data     (phv_data),
        .phv_valid    (phv_valid),
        .phv_ready    (phv_ready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pkt_cnt      (pkt_cnt),
        .short_cnt    (short_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seg_val(input int p, input int k);
        logic [31:0] w;
        w = 32'hA500_0000 | (p << 8) | k;
        return {8{w}};
    endfunction

    function automatic logic [DW-1:0] in_data(input int p, input int b);
        logic [31:0] w;
        w = 32'hD000_0000 | (p << 8) | b;
        return {8{w}};
    endfunction

    function automatic logic [TU-1:0] in_user(input int p, input int b);
        logic [31:0] hi;
        hi = 32'hCAFE_0000 | p;
        return {hi, 64'h0123_4567_89AB_CDEF, 8'h77, 8'h5A, 8'(p), 8'(b)};
    endfunction

    function automatic logic [TU-1:0] exp_user0(input int p, input int len);
        logic [TU-1:0] u;
        u = in_user(p, 0);
        u[31:24] = 8'h04;
        if (!FWD) u[15:0] = 16'(len);
        return u;
    endfunction

    function automatic logic [PW-1:0] mk_phv(input int p, input int len);
        logic [PW-1:0] v;
        for (int k = 0; k < HB; k++) v[k*DW +: DW] = seg_val(p, k);
        v[HB*DW +: LW] = 16'(len);
        return v;
    endfunction

    function automatic logic [OW-1:0] pack(input logic [DW-1:0] d,
                                           input logic [KW-1:0] k,
                                           input logic [TU-1:0] u,
                                           input logic l);
        return {d, k, u, l};
    endfunction

    task automatic push_pkt(input int p, input int len, input int nb,
                            input logic [KW-1:0] lk);
        pq.push_back(mk_phv(p, len));
        for (int b = 0; b < nb; b++) begin
            iq_data.push_back(in_data(p, b));
            iq_keep.push_back((b == nb - 1) ? lk : {KW{1'b1}});
            iq_user.push_back(in_user(p, b));
            iq_last.push_back(b == nb - 1);
        end
    endtask

    task automatic clear_q();
        iq_data.delete();
        iq_keep.delete();
        iq_user.delete();
        iq_last.delete();
        pq.delete();
        oq.delete();
        exq.delete();
        phv_pulses = 0;
        stall_err = 0;
    endtask

    // Cycle engine: drives queued beats/PHVs, captures accepted outputs.
    task automatic run(input int rdy_mode, input int stop_in, input int budget);
        int n;
        int fires;
        logic stalled;
        logic in_f;
        logic out_f;
        logic pr;
        logic [OW-1:0] prev;
        logic [OW-1:0] cur;
        n = 0;
        fires = 0;
        stalled = 1'b0;
        prev = '0;
        first_in = -1;
        last_in = -1;
        forever begin
            @(negedge clk);
            s_axis_tvalid = (iq_data.size() != 0);
            if (s_axis_tvalid) begin
                s_axis_tdata = iq_data[0];
                s_axis_tkeep = iq_keep[0];
                s_axis_tuser = iq_user[0];
                s_axis_tlast = iq_last[0];
            end
            phv_valid = (pq.size() != 0);
            if (phv_valid) phv_data = pq[0];
            m_axis_tready = (rdy_mode == 0) || (n % 2 == 0);
            #1;
            cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            if (stalled && cur !== prev) stall_err++;
            if (iq_data.size() == 0 && !m_axis_tvalid) break;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL run_timeout cycles=%0d limit=%0d", n, budget);
                break;
            end
            in_f = s_axis_tvalid && s_axis_tready;
            out_f = m_axis_tvalid && m_axis_tready;
            pr = phv_ready;
            stalled = m_axis_tvalid && !m_axis_tready;
            prev = cur;
            @(posedge clk);
            if (in_f) begin
                void'(iq_data.pop_front());
                void'(iq_keep.pop_front());
                void'(iq_user.pop_front());
                void'(iq_last.pop_front());
                fires++;
                if (first_in < 0) first_in = n;
                last_in = n;
            end
            if (pr) begin
                phv_pulses++;
                if (pq.size() != 0) void'(pq.pop_front());
            end
            if (out_f) oq.push_back(cur);
            n++;
            if (stop_in > 0 && fires >= stop_in) break;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = in_data(0, 0);
        s_axis_tkeep = '1;
        s_axis_tuser = in_user(0, 0);
        s_axis_tlast = 1'b0;
        phv_valid = 1'b1;
        phv_data = mk_phv(0, 64);
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid);
        end
        checks++;
        if (m_axis_tlast !== 1'b0) begin
            failures++;
            $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
            failures++;
            $display("FAIL rst_data got=%h/%h exp=0", m_axis_tdata, m_axis_tkeep);
        end
        checks++;
        if (m_axis_tuser !== '0) begin
            failures++;
            $display("FAIL rst_tuser got=%h exp=0", m_axis_tuser);
        end
        checks++;
        if (s_axis_tready !== 1'b0 || phv_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready got=%b%b exp=00", s_axis_tready, phv_ready);
        end
        checks++;
        if (pkt_cnt !== 32'd0 || short_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_cnt got=%0d/%0d exp=0/0", pkt_cnt, short_cnt);
        end
        s_axis_tvalid = 1'b0;
        phv_valid = 1'b0;
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifndef PHV_DEPARSER_PAYLOAD_FWD_EN
    task automatic test_trunc();
        logic [31:0] pc0;
        clear_q();
        pc0 = pkt_cnt;
        push_pkt(1, 40, 3, {KW{1'b1}});
        exq.push_back(pack(seg_val(1, 0), {KW{1'b1}}, exp_user0(1, 40), 1'b0));
        exq.push_back(pack(seg_val(1, 1), 32'h0000_00FF, in_user(1, 1), 1'b1));
        run(0, 0, 100);
        checks++;
        if (oq.size() != exq.size()) begin
            failures++;
            $display("FAIL trunc_count got=%0d exp=%0d", oq.size(), exq.size());
        end
        for (int b = 0; b < exq.size(); b++) begin
            checks++;
            if (b >= oq.size() || oq[b] !== exq[b]) begin
                failures++;
                $display("FAIL trunc_beat%0d got=%h exp=%h", b,
                         (b < oq.size()) ? oq[b] : {OW{1'bx}}, exq[b]);
            end
        end
        checks++;
        if (phv_pulses != 1 || iq_data.size() != 0) begin
            failures++;
            $display("FAIL trunc_phv got=%0d left=%0d exp=1/0", phv_pulses, iq_data.size());
        end
        checks++;
        if (pkt_cnt - pc0 !== 32'd1) begin
            failures++;
            $display("FAIL trunc_pkt_cnt got=%0d exp=%0d", pkt_cnt, pc0 + 1);
        end
    endtask
`else
    task automatic test_fwd();
        clear_q();
        push_pkt(5, 64, 6, 32'h0000_000F);
        exq.push_back(pack(seg_val(5, 0), {KW{1'b1}}, exp_user0(5, 64), 1'b0));
        exq.push_back(pack(seg_val(5, 1), {KW{1'b1}}, in_user(5, 1), 1'b0));
        for (int b = 2; b < 6; b++) begin
            exq.push_back(pack(in_data(5, b), (b == 5) ? 32'h0000_000F : {KW{1'b1}},
                               in_user(5, b), b == 5));
        end
        run(0, 0, 100);
        checks++;
        if (oq.size() != exq.size()) begin
            failures++;
            $display("FAIL fwd_count got=%0d exp=%0d", oq.size(), exq.size());
        end
        for (int b = 0; b < exq.size(); b++) begin
            checks++;
            if (b >= oq.size() || oq[b] !== exq[b]) begin
                failures++;
                $display("FAIL fwd_beat%0d got=%h exp=%h", b,
                         (b < oq.size()) ? oq[b] : {OW{1'bx}}, exq[b]);
            end
        end
        checks++;
        if (phv_pulses != 1) begin
            failures++;
            $display("FAIL fwd_phv got=%0d exp=1", phv_pulses);
        end
    endtask
`endif

    task automatic test_full();
        clear_q();
        push_pkt(2, 128, 4, {KW{1'b1}});
        for (int b = 0; b < 4; b++) begin
            exq.push_back(pack(seg_val(2, b), {KW{1'b1}},
                               (b == 0) ? exp_user0(2, 128) : in_user(2, b), b == 3));
        end
        run(0, 0, 100);
        checks++;
        if (oq.size() != exq.size()) begin
            failures++;
            $display("FAIL full_count got=%0d exp=%0d", oq.size(), exq.size());
        end
        for (int b = 0; b < exq.size(); b++) begin
            checks++;
            if (b >= oq.size() || oq[b] !== exq[b]) begin
                failures++;
                $display("FAIL full_beat%0d got=%h exp=%h", b,
                         (b < oq.size()) ? oq[b] : {OW{1'bx}}, exq[b]);
            end
        end
        // Idle with no PHV must not be ready; a stray DROP state would be.
        checks++;
        if (s_axis_tready !== 1'b0 || phv_pulses != 1) begin
            failures++;
            $display("FAIL full_idle got=%b/%0d exp=0/1", s_axis_tready, phv_pulses);
        end
    endtask

    task automatic test_short();
        logic [31:0] sc0;
        clear_q();
        sc0 = short_cnt;
        push_pkt(3, 96, 2, 32'h0000_FFFF);
        push_pkt(4, 64, 2, {KW{1'b1}});
        exq.push_back(pack(seg_val(3, 0), {KW{1'b1}}, exp_user0(3, 96), 1'b0));
        exq.push_back(pack(seg_val(3, 1), 32'h0000_FFFF, in_user(3, 1), 1'b1));
        exq.push_back(pack(seg_val(4, 0), {KW{1'b1}}, exp_user0(4, 64), 1'b0));
        exq.push_back(pack(seg_val(4, 1), {KW{1'b1}}, in_user(4, 1), 1'b1));
        run(0, 0, 100);
        checks++;
        if (oq.size() != exq.size()) begin
            failures++;
            $display("FAIL short_count got=%0d exp=%0d", oq.size(), exq.size());
        end
        for (int b = 0; b < exq.size(); b++) begin
            checks++;
            if (b >= oq.size() || oq[b] !== exq[b]) begin
                failures++;
                $display("FAIL short_beat%0d got=%h exp=%h", b,
                         (b < oq.size()) ? oq[b] : {OW{1'bx}}, exq[b]);
            end
        end
        checks++;
        if (short_cnt - sc0 !== 32'd1) begin
            failures++;
            $display("FAIL short_cnt got=%0d exp=%0d", short_cnt, sc0 + 1);
        end
        checks++;
        if (phv_pulses != 2 || pq.size() != 0) begin
            failures++;
            $display("FAIL short_phv got=%0d left=%0d exp=2/0", phv_pulses, pq.size());
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        push_pkt(6, 128, 4, {KW{1'b1}});
        push_pkt(7, 128, 4, {KW{1'b1}});
        for (int p = 6; p < 8; p++) begin
            for (int b = 0; b < 4; b++) begin
                exq.push_back(pack(seg_val(p, b), {KW{1'b1}},
                                   (b == 0) ? exp_user0(p, 128) : in_user(p, b), b == 3));
            end
        end
        run(1, 0, 200);
        checks++;
        if (oq.size() != exq.size()) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", oq.size(), exq.size());
        end
        for (int b = 0; b < exq.size(); b++) begin
            checks++;
            if (b >= oq.size() || oq[b] !== exq[b]) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h exp=%h", b,
                         (b < oq.size()) ? oq[b] : {OW{1'bx}}, exq[b]);
            end
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL bp_stable got=%0d exp=0", stall_err);
        end
        checks++;
        if (phv_pulses != 2) begin
            failures++;
            $display("FAIL bp_phv got=%0d exp=2", phv_pulses);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        push_pkt(8, 128, 4, {KW{1'b1}});
        push_pkt(9, 128, 4, {KW{1'b1}});
        for (int p = 8; p < 10; p++) begin
            for (int b = 0; b < 4; b++) begin
                exq.push_back(pack(seg_val(p, b), {KW{1'b1}},
                                   (b == 0) ? exp_user0(p, 128) : in_user(p, b), b == 3));
            end
        end
        run(0, 0, 100);
        checks++;
        if (last_in - first_in != 7) begin
            failures++;
            $display("FAIL b2b_span got=%0d exp=7", last_in - first_in);
        end
        checks++;
        if (oq.size() != exq.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", oq.size(), exq.size());
        end
        for (int b = 0; b < exq.size(); b++) begin
            checks++;
            if (b >= oq.size() || oq[b] !== exq[b]) begin
                failures++;
                $display("FAIL b2b_beat%0d got=%h exp=%h", b,
                         (b < oq.size()) ? oq[b] : {OW{1'bx}}, exq[b]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        push_pkt(10, 128, 4, {KW{1'b1}});
        run(0, 2, 50);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_tvalid got=%b exp=0", m_axis_tvalid);
        end
        checks++;
        if (pkt_cnt !== 32'd0 || short_cnt !== 32'd0) begin
            failures++;
            $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", pkt_cnt, short_cnt);
        end
        clear_q();
        s_axis_tvalid = 1'b0;
        phv_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        push_pkt(11, 128, 4, {KW{1'b1}});
        for (int b = 0; b < 4; b++) begin
            exq.push_back(pack(seg_val(11, b), {KW{1'b1}},
                               (b == 0) ? exp_user0(11, 128) : in_user(11, b), b == 3));
        end
        run(0, 0, 100);
        checks++;
        if (oq.size() != exq.size()) begin
            failures++;
            $display("FAIL midrst_count got=%0d exp=%0d", oq.size(), exq.size());
        end
        for (int b = 0; b < exq.size(); b++) begin
            checks++;
            if (b >= oq.size() || oq[b] !== exq[b]) begin
                failures++;
                $display("FAIL midrst_beat%0d got=%h exp=%h", b,
                         (b < oq.size()) ? oq[b] : {OW{1'bx}}, exq[b]);
            end
        end
        checks++;
        if (pkt_cnt !== 32'd1) begin
            failures++;
            $display("FAIL midrst_pkt_cnt got=%0d exp=1", pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
`ifdef PHV_DEPARSER_PAYLOAD_FWD_EN
        test_fwd();
`else
        test_trunc();
`endif
        test_full();
        test_short();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
